pellet_tracker: RTL and testbench
=================================

Name: pellet_tracker

Overview:
Downstream consumer of the player-motion block. Each frame_clk it takes the player position (BallX/BallY) and maps it to a maze tile. If that tile still holds a pellet, it clears the pellet, adds to a BCD score and decrements the remaining-pellet count. It also gives the color mapper a combinational pellet lookup for the current draw pixel, and flags level completion.

Parameters:
- TILE_SHIFT, 4, log2 of tile size in pixels (16 px tiles)
- ORIGIN_X, 16, pixel X of the left edge of tile column 0
- ORIGIN_Y, 16, pixel Y of the top edge of tile row 0
- COLS, 38, tile columns in the pellet field
- ROWS, 28, tile rows in the pellet field
- CNT_W, 11, width of pellets_left; must satisfy 2^CNT_W > COLS*ROWS

Ports:
- frame_clk  in  1  frame clock; the only clock
- Reset  in  1  synchronous, active-high reset
- BallX  in  10  player X pixel position
- BallY  in  10  player Y pixel position
- DrawX  in  10  current draw pixel X from the VGA controller
- DrawY  in  10  current draw pixel Y from the VGA controller
- pellet_pix  out  1  combinational; 1 when the tile containing (DrawX, DrawY) holds a pellet
- eat_pulse  out  1  registered; one-cycle pulse per pellet eaten
- score_bcd  out  16  registered; 4-digit packed BCD score
- pellets_left  out  CNT_W  registered; pellets remaining
- all_eaten  out  1  registered; level complete
- init_busy  out  1  high while the bitmap is being filled

Behaviour:
- Clocking and reset: one clock, frame_clk. Reset is synchronous and active-high; it is sampled only on the rising edge of frame_clk.
- Storage: COLS*ROWS-bit pellet bitmap; bit = 1 means a pellet is present.
- Tile mapping:
  - col = (X - ORIGIN_X) >> TILE_SHIFT; row = (Y - ORIGIN_Y) >> TILE_SHIFT.
  - A position is in-field only if X >= ORIGIN_X, Y >= ORIGIN_Y, col < COLS and row < ROWS.
  - Compare before subtracting so there is no 10-bit underflow.
- FSM states: INIT, RUN, DONE.
- Reset effect: state <= INIT, init_row <= 0, score_bcd <= 16'h0000, pellets_left <= 0, all_eaten <= 0, eat_pulse <= 0.
  - init_busy is (state == INIT), so it reads 1 immediately after reset.
  - Reset in any state, including mid-INIT or DONE, restarts from this point.
- INIT:
  - Each cycle, set all bits of row init_row and increment init_row.
  - On the cycle row ROWS-1 is written: load pellets_left <= COLS*ROWS and go to RUN. INIT therefore lasts exactly ROWS cycles.
  - No eating during INIT; pellet_pix is forced to 0.
- RUN:
  - Sample BallX/BallY on edge N. If in-field and the bit is 1, then on that same edge:
    - clear the bit;
    - eat_pulse <= 1;
    - score_bcd <= score_bcd + 10 in BCD;
    - pellets_left <= pellets_left - 1.
  - Outputs are visible in cycle N+1 (one-cycle latency). Otherwise eat_pulse <= 0.
  - If pellets_left is 1 and an eat occurs, go to DONE and set all_eaten <= 1 on the same edge.
- DONE:
  - all_eaten held at 1; eating disabled; eat_pulse 0.
  - Bitmap frozen; pellet_pix still reflects it (all 0 when completed normally).
  - DONE is left only by Reset.
- Boundary rules:
  - Player held on the same tile yields exactly one eat, because the bit is already 0 on later cycles.
  - Out-of-field position: no bitmap access, no score change.
  - Score addition: BCD tens digit +1 with decimal carry into the hundreds and thousands digits. Units digit is always 0.
  - Score saturates at 16'h9990 (an eat at 9990 leaves the score unchanged; the pellet is still cleared and counted).
  - pellets_left never underflows.
- pellet_pix: purely combinational from DrawX/DrawY and the bitmap. It is 0 outside the field.

Decomposition:
- Package pacman_pkg holds:
  - TILE_SHIFT, ORIGIN_X, ORIGIN_Y, COLS, ROWS;
  - the pt_state_t enum {INIT, RUN, DONE};
  - a function pix_to_tile returning {in_field, col, row}, shared by the eat path and the pellet_pix path.
- One sub-module: bcd_add10_sat. Combinational 16-bit packed BCD input, plus 10 with saturation at 9990, 16-bit output.

Test Plan:
- Reset held 1 cycle, then wait -> init_busy = 1 for 28 cycles, then 0; pellets_left = 1064; score_bcd = 0000; pellet_pix = 1 at DrawX=20, DrawY=20.
- BallX=16, BallY=16 in RUN -> next cycle eat_pulse = 1, score_bcd = 0010, pellets_left = 1063, pellet_pix = 0 at (20,20). Hold the position 5 more cycles -> no further pulses.
- BallX=10, BallY=100 (left of field) -> no eat_pulse, score and count unchanged. BallX=16, BallY=500 -> same.
- Walk 10 distinct tiles -> score_bcd = 0100 (carry into hundreds digit); pellets_left = 1054.
- COLS=2, ROWS=2: eat all 4 tiles -> all_eaten = 1 on the 4th eat; a later new position gives no eat_pulse. Reset -> all_eaten = 0, init_busy = 1, score 0000.
- Reset asserted mid-INIT (cycle 10) and mid-RUN (score 0030) -> INIT restarts from row 0 for 28 cycles; score_bcd = 0000.

Source files
------------

// File: rtl/pacman_pkg.sv
// pacman_pkg - shared constants, FSM state type and the pixel-to-tile mapping
// used by the pellet tracker.
//
// Contents:
//   TILE_SHIFT, ORIGIN_X, ORIGIN_Y, COLS, ROWS, CNT_W : default field geometry
//   pt_state_t  : pellet tracker FSM states
//   tile_t      : {in_field, col, row} result of a pixel-to-tile lookup
//   pix_to_tile : maps a 10-bit pixel position to a tile of the pellet field
package pacman_pkg;

    localparam int TILE_SHIFT = 4;
    localparam int ORIGIN_X   = 16;
    localparam int ORIGIN_Y   = 16;
    localparam int COLS       = 38;
    localparam int ROWS       = 28;
    localparam int CNT_W      = 11;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } pt_state_t;

    typedef struct packed {
        logic       in_field;
        logic [9:0] col;
        logic [9:0] row;
    } tile_t;

    // Geometry is passed in so that instances with a non-default field size
    // share the same mapping. The origin comparison happens before the
    // subtraction so that positions left of/above the field cannot wrap.
    function automatic tile_t pix_to_tile(
        input logic [9:0] x,
        input logic [9:0] y,
        input int         origin_x,
        input int         origin_y,
        input int         tile_shift,
        input int         cols,
        input int         rows
    );
        tile_t      t;
        logic [9:0] dx;
        logic [9:0] dy;
        t  = '0;
        dx = '0;
        dy = '0;
        if ((x >= 10'(origin_x)) && (y >= 10'(origin_y))) begin
            dx         = x - 10'(origin_x);
            dy         = y - 10'(origin_y);
            t.col      = dx >> tile_shift;
            t.row      = dy >> tile_shift;
            t.in_field = (t.col < 10'(cols)) && (t.row < 10'(rows));
        end
        return t;
    endfunction

endpackage

// File: rtl/pellet_tracker_bcd_add10_sat.sv
// bcd_add10_sat - combinational packed-BCD "+10" with saturation at 9990.
//
// Ports:
//   score_i [15:0] : 4-digit packed BCD input (units digit expected 0)
//   score_o [15:0] : score_i + 10 in BCD, or score_i unchanged at 9990
module bcd_add10_sat (
    input  logic [15:0] score_i,
    output logic [15:0] score_o
);

    always_comb begin
        score_o = score_i;
        // Tens, hundreds and thousands all at 9 means we are at the ceiling.
        if (score_i[15:4] != 12'h999) begin
            if (score_i[7:4] != 4'd9) begin
                score_o[7:4] = score_i[7:4] + 4'd1;
            end else begin
                score_o[7:4] = 4'd0;
                if (score_i[11:8] != 4'd9) begin
                    score_o[11:8] = score_i[11:8] + 4'd1;
                end else begin
                    score_o[11:8]  = 4'd0;
                    score_o[15:12] = score_i[15:12] + 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/pellet_tracker.sv
// pellet_tracker - pellet bitmap, eat detection and BCD scoring for the maze.
//
// Ports:
//   frame_clk    : frame clock, the only clock
//   Reset        : synchronous active-high reset
//   BallX/BallY  : player pixel position, sampled every frame in RUN
//   DrawX/DrawY  : current VGA draw pixel
//   pellet_pix   : combinational, 1 when the draw pixel's tile holds a pellet
//   eat_pulse    : registered one-cycle pulse per pellet eaten
//   score_bcd    : registered 4-digit packed BCD score
//   pellets_left : registered count of remaining pellets
//   all_eaten    : registered level-complete flag
//   init_busy    : high while the bitmap is being filled (state INIT)
module pellet_tracker
    import pacman_pkg::*;
#(
    parameter int TILE_SHIFT = pacman_pkg::TILE_SHIFT,
    parameter int ORIGIN_X   = pacman_pkg::ORIGIN_X,
    parameter int ORIGIN_Y   = pacman_pkg::ORIGIN_Y,
    parameter int COLS       = pacman_pkg::COLS,
    parameter int ROWS       = pacman_pkg::ROWS,
    parameter int CNT_W      = pacman_pkg::CNT_W
) (
    input  logic             frame_clk,
    input  logic             Reset,
    input  logic [9:0]       BallX,
    input  logic [9:0]       BallY,
    input  logic [9:0]       DrawX,
    input  logic [9:0]       DrawY,
    output logic             pellet_pix,
    output logic             eat_pulse,
    output logic [15:0]      score_bcd,
    output logic [CNT_W-1:0] pellets_left,
    output logic             all_eaten,
    output logic             init_busy
);

    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

    pt_state_t                   state_q;
    logic [RW-1:0]               init_row_q;
    logic [ROWS-1:0][COLS-1:0]   bitmap_q;
    logic [15:0]                 score_q;
    logic [15:0]                 score_d;
    logic [CNT_W-1:0]            left_q;
    logic                        eat_q;
    logic                        all_eaten_q;

    tile_t ball_t;
    tile_t draw_t;
    logic  ball_hit;

    assign ball_t = pix_to_tile(BallX, BallY, ORIGIN_X, ORIGIN_Y, TILE_SHIFT, COLS, ROWS);
    assign draw_t = pix_to_tile(DrawX, DrawY, ORIGIN_X, ORIGIN_Y, TILE_SHIFT, COLS, ROWS);

    // in_field guarantees the truncated indices are in range.
    assign ball_hit = ball_t.in_field && bitmap_q[ball_t.row[RW-1:0]][ball_t.col[CW-1:0]];

    assign pellet_pix = (state_q != INIT) && draw_t.in_field
                        && bitmap_q[draw_t.row[RW-1:0]][draw_t.col[CW-1:0]];

    // High tile-index bits are only used through in_field.
    logic unused_tile_bits;
    assign unused_tile_bits = ^{ball_t.row[9:RW], ball_t.col[9:CW],
                                draw_t.row[9:RW], draw_t.col[9:CW]};

    bcd_add10_sat u_add (
        .score_i (score_q),
        .score_o (score_d)
    );

    // The bitmap has no reset: INIT rewrites every row before it is used.
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state_q     <= INIT;
            init_row_q  <= '0;
            score_q     <= 16'h0000;
            left_q      <= '0;
            all_eaten_q <= 1'b0;
            eat_q       <= 1'b0;
        end else begin
            unique case (state_q)
                INIT: begin
                    eat_q                <= 1'b0;
                    bitmap_q[init_row_q] <= '1;
                    init_row_q           <= init_row_q + RW'(1);
                    if (init_row_q == RW'(ROWS - 1)) begin
                        left_q  <= CNT_W'(COLS * ROWS);
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    eat_q <= 1'b0;
                    if (ball_hit && (left_q != '0)) begin
                        bitmap_q[ball_t.row[RW-1:0]][ball_t.col[CW-1:0]] <= 1'b0;
                        eat_q   <= 1'b1;
                        score_q <= score_d;
                        left_q  <= left_q - CNT_W'(1);
                        if (left_q == CNT_W'(1)) begin
                            state_q     <= DONE;
                            all_eaten_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    eat_q       <= 1'b0;
                    all_eaten_q <= 1'b1;
                end
                default: begin
                    state_q <= INIT;
                end
            endcase
        end
    end

    assign eat_pulse    = eat_q;
    assign score_bcd    = score_q;
    assign pellets_left = left_q;
    assign all_eaten    = all_eaten_q;
    assign init_busy    = (state_q == INIT);

endmodule

// File: tb/tb_pellet_tracker.sv
// tb_pellet_tracker - directed bench for pellet_tracker: a full-size instance
// checked against a tile/score model with an expected-result queue, plus a
// 2x2 instance for level completion.
module tb_pellet_tracker;

    localparam int CNT_W = 11;
    localparam int NC    = 38;
    localparam int NR    = 28;

    logic             frame_clk;
    logic             rst, rst_s;
    logic [9:0]       ball_x, ball_y, draw_x, draw_y;
    logic [9:0]       ball_s_x, ball_s_y, draw_s_x, draw_s_y;
    logic             pellet_pix, eat_pulse, all_eaten, init_busy;
    logic [15:0]      score_bcd;
    logic [CNT_W-1:0] pellets_left;
    logic             pellet_pix_s, eat_pulse_s, all_eaten_s, init_busy_s;
    logic [15:0]      score_bcd_s;
    logic [CNT_W-1:0] pellets_left_s;

    int n_checks = 0;
    int n_fail   = 0;

    // Model of the full-size instance.
    bit mdl[NR][NC];
    int m_score;
    int m_left;
    bit m_done;
    logic [16+CNT_W-1:0] exp_q[$];

    // ---------------- clock / reset ----------------
    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    pellet_tracker dut (
        .frame_clk    (frame_clk),
        .Reset        (rst),
        .BallX        (ball_x),
        .BallY        (ball_y),
        .DrawX        (draw_x),
        .DrawY        (draw_y),
        .pellet_pix   (pellet_pix),
        .eat_pulse    (eat_pulse),
        .score_bcd    (score_bcd),
        .pellets_left (pellets_left),
        .all_eaten    (all_eaten),
        .init_busy    (init_busy)
    );

    pellet_tracker #(.COLS(2), .ROWS(2)) dut_s (
        .frame_clk    (frame_clk),
        .Reset        (rst_s),
        .BallX        (ball_s_x),
        .BallY        (ball_s_y),
        .DrawX        (draw_s_x),
        .DrawY        (draw_s_y),
        .pellet_pix   (pellet_pix_s),
        .eat_pulse    (eat_pulse_s),
        .score_bcd    (score_bcd_s),
        .pellets_left (pellets_left_s),
        .all_eaten    (all_eaten_s),
        .init_busy    (init_busy_s)
    );

    // ---------------- helpers ----------------
    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < NC; c++)
                mdl[r][c] = 1'b1;
        m_score = 0;
        m_left  = NC * NR;
        m_done  = 1'b0;
        exp_q.delete();
    endtask

    // All drivers run at posedge+1.
    task automatic do_reset();
        rst = 1'b1;
        @(posedge frame_clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic wait_init(input string tag);
        int cnt;
        cnt = 0;
        while (init_busy && cnt < 100) begin
            cnt++;
            @(posedge frame_clk);
            #1;
        end
        chk({tag, "_init_cycles"}, 32'(cnt), 32'd28);
    endtask

    // Drive one ball position for one frame and check the result.
    task automatic ball_step(input int x, input int y);
        int  c, r;
        bit  exp_eat;
        logic [16+CNT_W-1:0] e;
        ball_x  = 10'(x);
        ball_y  = 10'(y);
        exp_eat = 1'b0;
        c = (x - 16) / 16;
        r = (y - 16) / 16;
        if (!m_done && x >= 16 && y >= 16 && c < NC && r < NR && mdl[r][c]) begin
            exp_eat   = 1'b1;
            mdl[r][c] = 1'b0;
            if (m_score < 9990) m_score += 10;
            m_left--;
            if (m_left == 0) m_done = 1'b1;
            exp_q.push_back({to_bcd(m_score), CNT_W'(m_left)});
        end
        @(posedge frame_clk);
        #1;
        chk("eat_pulse", 32'(eat_pulse), 32'(exp_eat));
        chk("all_eaten", 32'(all_eaten), 32'(m_done));
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("score_bcd", 32'(score_bcd), 32'(e[16+CNT_W-1:CNT_W]));
            chk("pellets_left", 32'(pellets_left), 32'(e[CNT_W-1:0]));
        end
    endtask

    task automatic ball_s_step(input int x, input int y, input bit exp_eat, input bit exp_done,
                               input int exp_score);
        ball_s_x = 10'(x);
        ball_s_y = 10'(y);
        @(posedge frame_clk);
        #1;
        chk("s_eat_pulse", 32'(eat_pulse_s), 32'(exp_eat));
        chk("s_all_eaten", 32'(all_eaten_s), 32'(exp_done));
        chk("s_score", 32'(score_bcd_s), 32'(to_bcd(exp_score)));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst      = 1'b1;
        rst_s    = 1'b1;
        ball_x   = '0;
        ball_y   = '0;
        draw_x   = 10'd20;
        draw_y   = 10'd20;
        ball_s_x = '0;
        ball_s_y = '0;
        draw_s_x = 10'd20;
        draw_s_y = 10'd20;
        model_reset();
        @(posedge frame_clk);
        #1;
        rst   = 1'b0;
        rst_s = 1'b0;

        // Reset state and INIT length
        chk("rst_init_busy", 32'(init_busy), 32'd1);
        chk("rst_score", 32'(score_bcd), 32'h0);
        chk("rst_left", 32'(pellets_left), 32'd0);
        chk("rst_eat_pulse", 32'(eat_pulse), 32'd0);
        chk("rst_all_eaten", 32'(all_eaten), 32'd0);
        chk("init_pix_forced0", 32'(pellet_pix), 32'd0);
        wait_init("first");
        chk("post_init_left", 32'(pellets_left), 32'd1064);
        chk("post_init_score", 32'(score_bcd), 32'h0);
        chk("post_init_pix", 32'(pellet_pix), 32'd1);
        draw_x = 10'd5;
        #1;
        chk("pix_outside", 32'(pellet_pix), 32'd0);

        // First eat and holding on the same tile
        ball_step(16, 16);
        chk("first_score", 32'(score_bcd), 32'h0010);
        chk("first_left", 32'(pellets_left), 32'd1063);
        draw_x = 10'd20;
        #1;
        chk("first_pix_cleared", 32'(pellet_pix), 32'd0);
        draw_x = 10'd36;
        #1;
        chk("neighbour_pix", 32'(pellet_pix), 32'd1);
        for (int i = 0; i < 5; i++) ball_step(16, 16);

        // Out-of-field positions, including just past the last column/row
        ball_step(10, 100);
        ball_step(16, 500);
        ball_step(16 + 16 * NC, 16);
        ball_step(16, 16 + 16 * NR);
        chk("oof_score", 32'(score_bcd), 32'h0010);
        chk("oof_left", 32'(pellets_left), 32'd1063);

        // Nine more distinct tiles: carry into the hundreds digit
        for (int i = 0; i < 9; i++) ball_step(32 + 16 * i + $urandom_range(0, 15), 16);
        chk("walk_score", 32'(score_bcd), 32'h0100);
        chk("walk_left", 32'(pellets_left), 32'd1054);

        // Reset mid-INIT restarts INIT from row 0
        do_reset();
        repeat (10) begin
            @(posedge frame_clk);
            #1;
        end
        chk("midinit_busy", 32'(init_busy), 32'd1);
        do_reset();
        wait_init("midinit");
        chk("midinit_score", 32'(score_bcd), 32'h0);
        chk("midinit_left", 32'(pellets_left), 32'd1064);

        // Reset mid-RUN with a nonzero score
        ball_step(16, 16);
        ball_step(32, 16);
        ball_step(48, 16);
        chk("midrun_score", 32'(score_bcd), 32'h0030);
        do_reset();
        chk("midrun_rst_score", 32'(score_bcd), 32'h0);
        chk("midrun_rst_busy", 32'(init_busy), 32'd1);
        wait_init("midrun");
        draw_x = 10'd20;
        #1;
        chk("midrun_pix_refilled", 32'(pellet_pix), 32'd1);

        // Eat the whole field: saturation at 9990 and level completion
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < NC; c++)
                ball_step(16 + 16 * c + $urandom_range(0, 15), 16 + 16 * r + $urandom_range(0, 15));
        chk("sat_score", 32'(score_bcd), 32'h9990);
        chk("done_left", 32'(pellets_left), 32'd0);
        chk("done_all_eaten", 32'(all_eaten), 32'd1);
        chk("done_pix", 32'(pellet_pix), 32'd0);
        ball_step(20, 20);
        chk("done_busy", 32'(init_busy), 32'd0);

        // 2x2 field
        chk("s_init_busy", 32'(init_busy_s), 32'd0);
        chk("s_left", 32'(pellets_left_s), 32'd4);
        chk("s_pix", 32'(pellet_pix_s), 32'd1);
        ball_s_step(20, 20, 1'b1, 1'b0, 10);
        ball_s_step(36, 20, 1'b1, 1'b0, 20);
        ball_s_step(20, 36, 1'b1, 1'b0, 30);
        chk("s_left3", 32'(pellets_left_s), 32'd1);
        ball_s_step(36, 36, 1'b1, 1'b1, 40);
        chk("s_left0", 32'(pellets_left_s), 32'd0);
        ball_s_step(52, 20, 1'b0, 1'b1, 40);
        ball_s_step(36, 20, 1'b0, 1'b1, 40);
        chk("s_pix_done", 32'(pellet_pix_s), 32'd0);
        rst_s = 1'b1;
        @(posedge frame_clk);
        #1;
        rst_s = 1'b0;
        chk("s_rst_all_eaten", 32'(all_eaten_s), 32'd0);
        chk("s_rst_busy", 32'(init_busy_s), 32'd1);
        chk("s_rst_score", 32'(score_bcd_s), 32'h0);
        repeat (2) begin
            @(posedge frame_clk);
            #1;
        end
        chk("s_reinit_busy", 32'(init_busy_s), 32'd0);
        chk("s_reinit_left", 32'(pellets_left_s), 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
